// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard unit: scoreboard entry layout,
// forward-select codes and default geometry.
package pipe_pkg;

  localparam int DEF_NREG  = 32;
  localparam int DEF_DEPTH = 3;
  localparam int MAX_RAW   = 8;

  localparam int FWD_RF  = 0;
  localparam int FWD_MEM = 1;
  localparam int FWD_WB  = 2;

  // dest is sized for the largest supported register file and zero-extended
  typedef struct packed {
    logic               valid;
    logic [MAX_RAW-1:0] dest;
    logic               regwrite;
    logic               memread;
  } sb_entry_t;

  function automatic logic is_live(input sb_entry_t e);
    return e.valid && e.regwrite && (e.dest != '0);
  endfunction

endpackage

// File: rtl/pipe_fwd_match.sv
// Youngest-match priority search over the forwardable scoreboard entries;
// entries[0] is EX, so a lower index is a younger producer.
module pipe_fwd_match
  import pipe_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int RAW    = 5,
  parameter int CODE_W = $clog2(DEPTH)
) (
  input  sb_entry_t         entries [DEPTH-1],
  input  logic [RAW-1:0]    src,
  input  logic              en,
  output logic [CODE_W-1:0] code
);

  // Scan oldest to youngest so the youngest live match overwrites the rest
  always_comb begin
    code = CODE_W'(FWD_RF);
    for (int k = DEPTH - 1; k >= 1; k--) begin
      if (en && is_live(entries[k-1]) && (entries[k-1].dest == MAX_RAW'(src))) begin
        code = CODE_W'(k);
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Load-use stall, redirect flush and registered operand-forward selects
// for the 5-stage core, driven by a scoreboard of in-flight instructions.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int NREG           = DEF_NREG,
  parameter int DEPTH          = DEF_DEPTH,
  parameter int REDIRECT_STAGE = 2,
  parameter int CW             = 16,
  localparam int RAW           = $clog2(NREG),
  localparam int FW            = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           res,
  input  logic           id_valid_i,
  input  logic [RAW-1:0] id_rs_i,
  input  logic [RAW-1:0] id_rt_i,
  input  logic           id_uses_rt_i,
  input  logic [RAW-1:0] id_dest_i,
  input  logic           id_regwrite_i,
  input  logic           id_memread_i,
  input  logic           redirect_i,
  output logic           stall_o,
  output logic           flush_o,
  output logic [FW-1:0]  fwd_a_o,
  output logic [FW-1:0]  fwd_b_o,
  output logic [CW-1:0]  stall_cnt_o,
  output logic [CW-1:0]  flush_cnt_o
);

  if (DEPTH < 2 || DEPTH > 6) begin : g_bad_depth
    $error("pipe_hazard_unit: DEPTH must be within 2..6");
  end
  if (REDIRECT_STAGE < 1 || REDIRECT_STAGE > DEPTH - 1) begin : g_bad_redirect
    $error("pipe_hazard_unit: REDIRECT_STAGE must be within 1..DEPTH-1");
  end
  if (RAW > MAX_RAW) begin : g_bad_nreg
    $error("pipe_hazard_unit: NREG exceeds scoreboard dest width");
  end

  sb_entry_t     sb     [1:DEPTH];
  sb_entry_t     search [DEPTH-1];
  sb_entry_t     id_entry;
  logic [FW-1:0] code_a;
  logic [FW-1:0] code_b;
  logic          kill;
  logic          unused_retire;

  always_comb begin
    for (int k = 0; k < DEPTH - 1; k++) begin
      search[k] = sb[k+1];
    end
  end

  // s[DEPTH] only retires; the WB-to-ID case is covered by register-file write-through
  assign unused_retire = is_live(sb[DEPTH]);

  assign id_entry = '{valid:    id_valid_i,
                      dest:     MAX_RAW'(id_dest_i),
                      regwrite: id_regwrite_i,
                      memread:  id_memread_i};

  assign flush_o = redirect_i;
  assign stall_o = id_valid_i && !redirect_i && is_live(sb[1]) && sb[1].memread &&
                   ((sb[1].dest == MAX_RAW'(id_rs_i)) ||
                    (id_uses_rt_i && (sb[1].dest == MAX_RAW'(id_rt_i))));
  assign kill    = stall_o || flush_o || !id_valid_i;

  pipe_fwd_match #(.DEPTH(DEPTH), .RAW(RAW), .CODE_W(FW)) u_match_a (
    .entries (search),
    .src     (id_rs_i),
    .en      (1'b1),
    .code    (code_a)
  );

  pipe_fwd_match #(.DEPTH(DEPTH), .RAW(RAW), .CODE_W(FW)) u_match_b (
    .entries (search),
    .src     (id_rt_i),
    .en      (id_uses_rt_i),
    .code    (code_b)
  );

  // Entries s[2..REDIRECT_STAGE] are younger than the redirecting instruction and die on shift
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int k = 1; k <= DEPTH; k++) begin
        sb[k] <= '0;
      end
      fwd_a_o     <= '0;
      fwd_b_o     <= '0;
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      sb[1] <= (stall_o || flush_o) ? '0 : id_entry;
      for (int k = 2; k <= DEPTH; k++) begin
        sb[k] <= sb[k-1];
        if (redirect_i && (k <= REDIRECT_STAGE)) begin
          sb[k].valid <= 1'b0;
        end
      end
      fwd_a_o <= kill ? FW'(FWD_RF) : code_a;
      fwd_b_o <= kill ? FW'(FWD_RF) : code_b;
      if (flush_o) begin
        if (flush_cnt_o != '1) flush_cnt_o <= flush_cnt_o + 1'b1;
      end else if (stall_o) begin
        if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Scoreboard bench for pipe_hazard_unit: a queue-based model of in-flight
// instructions predicts every cycle, a monitor compares, plus directed cases.
module tb_pipe_hazard_unit;

  localparam int NREG  = 32;
  localparam int DEPTH = 3;
  localparam int RSTG  = 2;
  localparam int RAW   = 5;
  localparam int FW    = 2;

  logic           clk = 1'b0;
  logic           res;
  logic           id_valid_i;
  logic [RAW-1:0] id_rs_i;
  logic [RAW-1:0] id_rt_i;
  logic           id_uses_rt_i;
  logic [RAW-1:0] id_dest_i;
  logic           id_regwrite_i;
  logic           id_memread_i;
  logic           redirect_i;
  logic           stall_o, flush_o, stall_s, flush_s;
  logic [FW-1:0]  fwd_a_o, fwd_b_o, fwd_a_s, fwd_b_s;
  logic [15:0]    stall_cnt_o, flush_cnt_o;
  logic [3:0]     stall_cnt_s, flush_cnt_s;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.NREG(NREG), .DEPTH(DEPTH), .REDIRECT_STAGE(RSTG), .CW(16)) dut (
    .clk(clk), .res(res), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .id_dest_i(id_dest_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .redirect_i(redirect_i), .stall_o(stall_o), .flush_o(flush_o),
    .fwd_a_o(fwd_a_o), .fwd_b_o(fwd_b_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  pipe_hazard_unit #(.NREG(NREG), .DEPTH(DEPTH), .REDIRECT_STAGE(RSTG), .CW(4)) dut_small (
    .clk(clk), .res(res), .id_valid_i(id_valid_i), .id_rs_i(id_rs_i), .id_rt_i(id_rt_i),
    .id_uses_rt_i(id_uses_rt_i), .id_dest_i(id_dest_i), .id_regwrite_i(id_regwrite_i),
    .id_memread_i(id_memread_i), .redirect_i(redirect_i), .stall_o(stall_s), .flush_o(flush_s),
    .fwd_a_o(fwd_a_s), .fwd_b_o(fwd_b_s), .stall_cnt_o(stall_cnt_s), .flush_cnt_o(flush_cnt_s)
  );

  typedef struct {
    bit stall; bit flush; int fa; int fb;
    int scnt; int fcnt; int scnt_s; int fcnt_s;
  } exp_t;

  typedef struct { bit v; int d; bit rw; bit mr; } minst_t;

  int     total = 0;
  int     bad = 0;
  bit     chk = 0;
  exp_t   exp_q[$];
  minst_t inflight[$];
  int     m_scnt, m_fcnt, m_scnt_s, m_fcnt_s;

  function automatic bit live(input minst_t x);
    return x.v && x.rw && (x.d != 0);
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input int expv);
    total++;
    if (act !== 32'(expv)) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic driveIdle();
    id_valid_i = 0; id_rs_i = '0; id_rt_i = '0; id_uses_rt_i = 0;
    id_dest_i = '0; id_regwrite_i = 0; id_memread_i = 0; redirect_i = 0;
  endtask

  // Drives one ID cycle and pushes the model's prediction for it
  task automatic applyStimulus(input bit v, input int rs, input int rt, input bit urt,
                               input int d, input bit rw, input bit mr, input bit redir);
    exp_t   e;
    minst_t ex, nw, tmp;
    int     fa, fb;
    bit     st, kill;
    @(negedge clk);
    id_valid_i = v; id_rs_i = RAW'(rs); id_rt_i = RAW'(rt); id_uses_rt_i = urt;
    id_dest_i = RAW'(d); id_regwrite_i = rw; id_memread_i = mr; redirect_i = redir;
    ex = inflight[0];
    st = v && !redir && live(ex) && ex.mr && (ex.d == rs || (urt && ex.d == rt));
    fa = 0; fb = 0;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      if (live(inflight[i]) && inflight[i].d == rs) fa = i + 1;
      if (urt && live(inflight[i]) && inflight[i].d == rt) fb = i + 1;
    end
    kill = st || redir || !v;
    if (redir) begin
      for (int i = 0; i <= RSTG - 2; i++) begin
        tmp = inflight[i]; tmp.v = 0; inflight[i] = tmp;
      end
    end
    nw.v = v && !st && !redir; nw.d = d; nw.rw = rw; nw.mr = mr;
    inflight.push_front(nw);
    void'(inflight.pop_back());
    if (redir) begin
      m_fcnt = sat(m_fcnt, 65535); m_fcnt_s = sat(m_fcnt_s, 15);
    end else if (st) begin
      m_scnt = sat(m_scnt, 65535); m_scnt_s = sat(m_scnt_s, 15);
    end
    e.stall = st; e.flush = redir;
    e.fa = kill ? 0 : fa; e.fb = kill ? 0 : fb;
    e.scnt = m_scnt; e.fcnt = m_fcnt; e.scnt_s = m_scnt_s; e.fcnt_s = m_fcnt_s;
    exp_q.push_back(e);
  endtask

  task automatic doReset();
    minst_t b;
    b.v = 0; b.d = 0; b.rw = 0; b.mr = 0;
    @(negedge clk);
    chk = 0; res = 1; driveIdle();
    exp_q.delete(); inflight.delete();
    for (int i = 0; i < DEPTH; i++) inflight.push_back(b);
    m_scnt = 0; m_fcnt = 0; m_scnt_s = 0; m_fcnt_s = 0;
    #1;
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_flush", flush_o, 0);
    checkOutput("rst_fwd_a", fwd_a_o, 0);
    checkOutput("rst_fwd_b", fwd_b_o, 0);
    checkOutput("rst_stall_cnt", stall_cnt_o, 0);
    checkOutput("rst_flush_cnt", flush_cnt_o, 0);
    @(negedge clk);
    res = 0; chk = 1;
  endtask

  // Monitor: combinational outputs mid-cycle, registered outputs after the edge
  initial begin
    exp_t rec;
    bit   have;
    forever begin
      @(negedge clk);
      #2;
      have = 0;
      if (chk && exp_q.size() > 0) begin
        rec = exp_q.pop_front();
        have = 1;
        checkOutput("sb_stall", stall_o, int'(rec.stall));
        checkOutput("sb_flush", flush_o, int'(rec.flush));
        checkOutput("sb_stall_small", stall_s, int'(rec.stall));
      end
      @(posedge clk);
      #1;
      if (chk && have) begin
        checkOutput("sb_fwd_a", fwd_a_o, rec.fa);
        checkOutput("sb_fwd_b", fwd_b_o, rec.fb);
        checkOutput("sb_stall_cnt", stall_cnt_o, rec.scnt);
        checkOutput("sb_flush_cnt", flush_cnt_o, rec.fcnt);
        checkOutput("sb_stall_cnt_small", stall_cnt_s, rec.scnt_s);
        checkOutput("sb_flush_cnt_small", flush_cnt_s, rec.fcnt_s);
      end
    end
  end

  initial begin
    res = 1; driveIdle();
    doReset();

    applyStimulus(1, 1, 2, 1, 3, 1, 0, 0);
    applyStimulus(1, 3, 1, 1, 4, 1, 0, 0);
    #1 checkOutput("b2b_stall", stall_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("b2b_fwd_a", fwd_a_o, 1);

    applyStimulus(1, 1, 2, 1, 3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 3, 1, 5, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("gap_fwd_a", fwd_a_o, 2);
    checkOutput("gap_fwd_b", fwd_b_o, 2);
    applyStimulus(1, 1, 2, 1, 3, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 3, 3, 0, 5, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("gap_fwd_a_nort", fwd_a_o, 2);
    checkOutput("gap_fwd_b_nort", fwd_b_o, 0);

    doReset();
    applyStimulus(1, 1, 0, 0, 2, 1, 1, 0);
    applyStimulus(1, 2, 7, 1, 6, 1, 0, 0);
    #1 checkOutput("lu_stall_on", stall_o, 1);
    applyStimulus(1, 2, 7, 1, 6, 1, 0, 0);
    #1 checkOutput("lu_stall_off", stall_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("lu_fwd_a", fwd_a_o, 2);
    checkOutput("lu_stall_cnt", stall_cnt_o, 1);

    applyStimulus(1, 1, 0, 0, 0, 1, 1, 0);
    applyStimulus(1, 0, 0, 1, 9, 1, 0, 0);
    #1 checkOutput("r0_stall", stall_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("r0_fwd_a", fwd_a_o, 0);
    checkOutput("r0_fwd_b", fwd_b_o, 0);

    doReset();
    applyStimulus(1, 1, 2, 1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 2, 1, 1, 0);
    applyStimulus(1, 2, 7, 1, 6, 1, 0, 1);
    #1 checkOutput("rd_flush", flush_o, 1);
    checkOutput("rd_stall", stall_o, 0);
    applyStimulus(1, 2, 0, 0, 8, 1, 0, 0);
    #1 checkOutput("rd_stall_after", stall_o, 0);
    checkOutput("rd_flush_cnt", flush_cnt_o, 1);
    checkOutput("rd_stall_cnt", stall_cnt_o, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1 checkOutput("rd_victim_fwd", fwd_a_o, 0);

    doReset();
    repeat (400) begin
      bit v, urt, rw, mr, redir;
      v     = ($urandom_range(0, 9) < 8);
      urt   = 1'($urandom_range(0, 1));
      rw    = ($urandom_range(0, 9) < 7);
      mr    = rw && ($urandom_range(0, 3) == 0);
      redir = ($urandom_range(0, 9) == 0);
      applyStimulus(v, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), urt,
                    int'($urandom_range(0, 7)), rw, mr, redir);
    end
    #1 checkOutput("sat_flush_small", flush_cnt_s, 15);

    doReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 1, 0, 0, 5, 1, 0, 0);
    applyStimulus(1, 5, 0, 0, 2, 1, 1, 0);
    applyStimulus(1, 2, 7, 1, 6, 1, 0, 0);
    #1 checkOutput("ar_stall_before", stall_o, 1);
    checkOutput("ar_fwd_a_before", fwd_a_o, 1);
    checkOutput("ar_flush_cnt_before", flush_cnt_o, 1);
    #2;
    chk = 0;
    res = 1;
    #1 checkOutput("ar_stall", stall_o, 0);
    checkOutput("ar_flush", flush_o, 0);
    checkOutput("ar_fwd_a", fwd_a_o, 0);
    checkOutput("ar_fwd_b", fwd_b_o, 0);
    checkOutput("ar_stall_cnt", stall_cnt_o, 0);
    checkOutput("ar_flush_cnt", flush_cnt_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
Name: pipe_hazard_unit

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipelined RISC core. Successor to the fixed, hazard-blind pipeline.
- Keeps a DEPTH-entry scoreboard of in-flight instructions past ID (EX, MEM, WB by default).
- Produces load-use stall, control-redirect flush, and registered per-operand forwarding selects aligned to EX.
- Counts stall and flush cycles for performance visibility.

Parameters:
- NREG, 32: architectural register count; RAW = $clog2(NREG) source/destination index width.
- DEPTH, 3: scoreboard stages after ID (s[1]=EX ... s[DEPTH]=WB); legal 2..6.
- REDIRECT_STAGE, 2: scoreboard stage resolving branch/jump (2 = MEM); legal 1..DEPTH-1.
- CW, 16: width of the saturating performance counters.

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  reset, asynchronous, active-high.
- id_valid_i  in  1  ID holds a real instruction.
- id_rs_i  in  RAW  first source register.
- id_rt_i  in  RAW  second source register.
- id_uses_rt_i  in  1  rt is read as an operand (R-type, store, branch).
- id_dest_i  in  RAW  final destination after RegDest mux.
- id_regwrite_i  in  1  ID instruction writes the register file.
- id_memread_i  in  1  ID instruction is a load.
- redirect_i  in  1  branch taken or jump, from stage REDIRECT_STAGE.
- stall_o  out  1  hold PC and IF/ID; insert a bubble into EX (combinational).
- flush_o  out  1  kill IF/ID and stages younger than REDIRECT_STAGE (combinational, equals redirect_i).
- fwd_a_o  out  $clog2(DEPTH)  EX rs operand source: 0 = register file, k = result of stage k+1.
- fwd_b_o  out  $clog2(DEPTH)  same encoding for the rt operand.
- stall_cnt_o  out  CW  cycles with stall_o=1 and flush_o=0.
- flush_cnt_o  out  CW  cycles with flush_o=1.

Behaviour:
- Scoreboard entry s[k] = {valid, dest, regwrite, memread}. Reset clears every valid, fwd_a_o, fwd_b_o and both counters; stall_o=0 and flush_o=0 follow.
- Each cycle s[k+1] <= s[k] for k = 1..DEPTH-1; s[DEPTH] retires.
- s[1] load:
  - {id_valid_i, id_dest_i, id_regwrite_i, id_memread_i} when neither stall nor flush;
  - a bubble (valid=0) otherwise.
- Live producer in s[k]: valid & regwrite & dest != 0. Register 0 never matches, never stalls, never forwards.
- stall_o = id_valid_i & !redirect_i & s[1] is a live load & (s[1].dest == id_rs_i, or id_uses_rt_i & s[1].dest == id_rt_i).
- Forward select, computed in ID and registered into EX:
  - Search s[1]..s[DEPTH-1]; the youngest (lowest k) live match wins and the code is k.
  - No match gives code 0. A load match at k >= 2 is legal forwarding.
  - The fwd_b search is qualified by id_uses_rt_i.
  - Registered select is forced to 0 when stall, flush or !id_valid_i, matching the bubble.
- WB-to-ID collision (match in s[DEPTH]) is resolved by register_file write-through and is outside this block.
- Flush:
  - redirect_i forces s[1] to a bubble.
  - Clears valid of s[2..REDIRECT_STAGE] as they shift, killing every instruction younger than the redirecting one.
  - The redirecting instruction itself proceeds.
- Redirect and load-use in the same cycle: flush wins, stall_o=0, only flush_cnt increments.
- Counters saturate at all-ones; no wrap.
- Reset asserted mid-operation empties the scoreboard asynchronously. Stall and forwarding deassert without waiting for a clock.
- Latency: stall_o and flush_o are 0-cycle. Forward selects are valid one cycle after ID, i.e. while the consumer is in EX.

Decomposition:
- Shared package pipe_pkg: scoreboard entry struct, forward-code constants (FWD_RF=0, FWD_MEM=1, FWD_WB=2), default NREG/DEPTH.
- One natural sub-module, pipe_fwd_match: combinational youngest-match priority search across DEPTH-1 entries. Instantiated twice, for rs and rt.

Test Plan:
- Back-to-back ALU dependency: add r3 at t0, then sub r4,r3,r1 at t1 -> fwd_a_o=1 at t2, stall_o=0.
- One-gap dependency: add r3, nop, and r5,r3,r3 -> fwd_a_o=2 and fwd_b_o=2 in EX; with id_uses_rt_i=0, fwd_b_o=0.
- Load-use: lw r2 then add r6,r2,r7 -> stall_o=1 for exactly one cycle, bubble in s[1], then fwd_a_o=2 and stall_cnt_o=1.
- Register 0: live producer writing r0 followed by a reader of r0 -> fwd codes 0, no stall.
- Redirect at MEM with a load-use in ID the same cycle -> flush_o=1, stall_o=0, s[1] and EX victim invalid next cycle, flush_cnt_o=1, stall_cnt_o=0.
- Async reset mid-stall -> stall_o drops before the next edge, all outputs 0; CW=4 saturation run holds the counter at 15.
